// File: rtl/mult_div_pkg.sv
// Shared op-codes, FSM state type and result width for the HI/LO multiply/divide unit.
// MULT_DIV_MADD_EN (optional) makes op 100/101 legal as MADD/MADDU.
package mult_div_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;

    localparam int RESULT_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Reserved op-codes must not launch anything, so the FSM gates start with this.
    function automatic logic isValidOp(input logic [2:0] op);
        logic valid;
        valid = 1'b0;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: valid = 1'b1;
`ifdef MULT_DIV_MADD_EN
            OP_MADD, OP_MADDU: valid = 1'b1;
`endif
            default: valid = 1'b0;
        endcase
        return valid;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit: operands, controls and HI/LO/busy results.
interface mult_div_unit_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, hi, lo
    );

endinterface

// File: rtl/mult_div_unit_md_calc.sv
// Combinational 64-bit HI/LO result from the latched operands; flags whether HI/LO should be written.
// MULT_DIV_MADD_EN adds the accumulate forms.
module md_calc
    import mult_div_pkg::*;
(
    input  logic [2:0]          i_op,
    input  logic [31:0]         i_a,
    input  logic [31:0]         i_b,
    input  logic [31:0]         i_hi,
    input  logic [31:0]         i_lo,
    output logic [RESULT_W-1:0] o_result,
    output logic                o_write
);

    logic                w_signedOp;
    logic                w_negA;
    logic                w_negB;
    logic [63:0]         w_product;
    logic [31:0]         w_magA;
    logic [31:0]         w_magB;
    logic [31:0]         w_divisor;
    logic [31:0]         w_quotMag;
    logic [31:0]         w_remMag;
    logic [31:0]         w_quot;
    logic [31:0]         w_rem;

    // Signed divide works on magnitudes, so 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        w_signedOp = (i_op == OP_MULT) || (i_op == OP_DIV) || (i_op == OP_MADD);
        w_negA     = w_signedOp && i_a[31];
        w_negB     = w_signedOp && i_b[31];
        w_product  = {{32{w_negA}}, i_a} * {{32{w_negB}}, i_b};
        w_magA     = w_negA ? (32'd0 - i_a) : i_a;
        w_magB     = w_negB ? (32'd0 - i_b) : i_b;
        w_divisor  = (i_b == 32'd0) ? 32'd1 : w_magB;
        w_quotMag  = w_magA / w_divisor;
        w_remMag   = w_magA % w_divisor;
        w_quot     = (w_negA != w_negB) ? (32'd0 - w_quotMag) : w_quotMag;
        w_rem      = w_negA ? (32'd0 - w_remMag) : w_remMag;

        o_result = {i_hi, i_lo};
        o_write  = 1'b0;
        case (i_op)
            OP_MULT, OP_MULTU: begin
                o_result = w_product;
                o_write  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                o_result = {w_rem, w_quot};
                o_write  = (i_b != 32'd0);
            end
`ifdef MULT_DIV_MADD_EN
            OP_MADD, OP_MADDU: begin
                o_result = {i_hi, i_lo} + w_product;
                o_write  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: FSM, latency counter and HI/LO registers.
// Define MULT_DIV_MADD_EN to enable MADD/MADDU (op 100/101).
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)
(
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    state_t              r_state;
    state_t              w_nextState;
    logic [31:0]         r_count;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [2:0]          r_op;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    logic                w_launch;
    logic                w_commit;
    logic                w_isDiv;
    logic                w_write;
    logic [RESULT_W-1:0] w_result;

    md_calc u_calc (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .o_result (w_result),
        .o_write  (w_write)
    );

    assign w_isDiv = (bus.op == OP_DIV) || (bus.op == OP_DIVU);

    always_comb begin
        w_nextState = r_state;
        w_launch    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && isValidOp(bus.op)) begin
                    w_launch    = 1'b1;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (r_count == 32'd1) begin
                    w_commit    = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= OP_MULT;
        end else begin
            r_state <= w_nextState;
            if (w_launch) begin
                r_count <= w_isDiv ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_op    <= bus.op;
            end else if (r_state == BUSY) begin
                r_count <= r_count - 32'd1;
            end
        end
    end

    // Any start in IDLE, even a reserved one, suppresses a same-cycle mthi/mtlo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (w_write) begin
                {r_hi, r_lo} <= w_result;
            end
        end else if (r_state == IDLE && !bus.start) begin
            if (bus.mthi) r_hi <= bus.a;
            if (bus.mtlo) r_lo <= bus.a;
        end
    end

    assign bus.busy = (r_state == BUSY);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
